// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) one instruction at a time,
// drives ALU opcode, mux selects and write strobes, and counts retirements.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes enter a sticky TRAP
// state); when undefined, illegal opcodes retire as NOPs and trap is tied 0.
module multicycle_ctrl #(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          inst,
   input  logic                 mem_ready,
   input  logic                 alu_zero,
   output logic                 mem_re,
   output logic                 mem_we,
   output logic                 ir_we,
   output logic                 ab_we,
   output logic                 pc_we,
   output logic [1:0]           pc_sel,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [3:0]           alu_op,
   output logic [1:0]           wb_sel,
   output logic                 reg_we,
   output logic [2:0]           state,
   output logic [INSTRET_W-1:0] instret,
   output logic                 trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   state_e                 state_q, state_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load, is_store, is_jal;
   logic       br_taken;
   logic       unused_inst;

   assign opcode   = inst[6:0];
   assign funct3   = inst[14:12];
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);
   assign is_jal   = (opcode == OPC_JAL);
   assign br_taken = ((funct3 == 3'b000) &  alu_zero) |
                     ((funct3 == 3'b001) & ~alu_zero);
   assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

   // State and retired-instruction counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Next-state and output decode; everything is forced to 0 while rst is high
   always_comb begin
      state_d   = state_q;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      ab_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op    = 4'b0000;
      wb_sel    = 2'b00;
      reg_we    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            ab_we   = 1'b1;
            state_d = S_EXEC;
         end

         S_EXEC: begin
            case (opcode)
               OPC_OP: begin
                  alu_op  = {inst[30] & ((funct3 == 3'b000) | (funct3 == 3'b101)), funct3};
                  state_d = S_WB;
               end
               OPC_OPIMM: begin
                  alu_src_b = 2'b01;
                  alu_op    = {inst[30] & (funct3 == 3'b101), funct3};
                  state_d   = S_WB;
               end
               OPC_LOAD, OPC_STORE: begin
                  alu_src_b = 2'b01;
                  state_d   = S_MEM;
               end
               OPC_BRANCH: begin
                  alu_op  = 4'b1000;
                  pc_we   = 1'b1;
                  pc_sel  = br_taken ? 2'b01 : 2'b00;
                  state_d = S_FETCH;
               end
               OPC_LUI: begin
                  alu_src_a = 2'b10;
                  alu_src_b = 2'b01;
                  state_d   = S_WB;
               end
               OPC_JAL: begin
                  state_d = S_WB;
               end
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
`endif
               end
            endcase
         end

         S_MEM: begin
            if (is_store) begin
               mem_we = 1'b1;
               if (mem_ready) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               mem_re = 1'b1;
               if (mem_ready) begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            wb_sel  = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
            pc_sel  = is_jal ? 2'b10 : 2'b00;
            state_d = S_FETCH;
         end

         S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (rst) begin
         state_d   = S_FETCH;
         mem_re    = 1'b0;
         mem_we    = 1'b0;
         ir_we     = 1'b0;
         ab_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = 2'b00;
         alu_src_a = 2'b00;
         alu_src_b = 2'b00;
         alu_op    = 4'b0000;
         wb_sel    = 2'b00;
         reg_we    = 1'b0;
      end
   end

   // An instruction retires exactly when the PC is written
   always_comb begin
      instret_d = instret_q;
      if (pc_we) begin
         instret_d = instret_q + INSTRET_W'(1);
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
   assign trap = (state_q == S_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases followed by random
// instruction streams with random fetch/memory wait states, checked cycle by
// cycle against an instruction-level reference model of the control sequence.
module tb_multicycle_ctrl;

   localparam int unsigned IW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   inst = '0;
   logic          mem_ready = 1'b1;
   logic          alu_zero = 1'b0;
   logic          mem_re, mem_we, ir_we, ab_we, pc_we, reg_we, trap;
   logic [1:0]    pc_sel, alu_src_a, alu_src_b, wb_sel;
   logic [3:0]    alu_op;
   logic [2:0]    state;
   logic [IW-1:0] instret;

   int            checks = 0;
   int            errors = 0;
   logic [IW-1:0] exp_instret = '0;
   logic [21:0]   obs;

   multicycle_ctrl #(.INSTRET_W(IW)) dut (
      .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .ab_we(ab_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .wb_sel(wb_sel), .reg_we(reg_we), .state(state), .instret(instret), .trap(trap)
   );

   always #5 clk = ~clk;

   assign obs = {mem_re, mem_we, ir_we, ab_we, pc_we, pc_sel, alu_src_a, alu_src_b,
                 alu_op, wb_sel, reg_we, state, trap};

   function automatic logic [21:0] ev(input logic re, input logic we, input logic irw,
                                      input logic abw, input logic pcw, input logic [1:0] ps,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] op, input logic [1:0] wb,
                                      input logic rw, input logic [2:0] st, input logic tr);
      return {re, we, irw, abw, pcw, ps, sa, sb, op, wb, rw, st, tr};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // One clock cycle: drive at negedge, check just after, model retire at posedge
   task automatic step(input logic [31:0] i, input logic rdy, input logic az,
                       input logic [21:0] e, input string tag, input bit ret);
      @(negedge clk);
      inst      = i;
      mem_ready = rdy;
      alu_zero  = az;
      #1;
      chk(tag, 32'(obs), 32'(e));
      chk({tag, "_instret"}, 32'(instret), 32'(exp_instret));
      @(posedge clk);
      if (ret) exp_instret += IW'(1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("reset_outputs", 32'(obs), 32'(ev(0,0,0,0,0,0,0,0,0,0,0,3'd0,0)));
      chk("reset_instret", 32'(instret), 32'd0);
      exp_instret = '0;
      @(negedge clk);
      mem_ready = 1'b0;
      rst       = 1'b0;
   endtask

   // Reference: expected control sequence for one instruction, from the ISA rules
   task automatic run_instr(input logic [31:0] i, input int unsigned fw,
                            input int unsigned mw, input logic az);
      logic [6:0] opc;
      logic [2:0] f3;
      bit         is_op, is_opi, is_ld, is_st, is_br, is_lui, is_jal, legal, pcw, taken;
      logic [1:0] sa, sb, ps;
      logic [3:0] op;
      opc    = i[6:0];
      f3     = i[14:12];
      is_op  = (opc == 7'h33);
      is_opi = (opc == 7'h13);
      is_ld  = (opc == 7'h03);
      is_st  = (opc == 7'h23);
      is_br  = (opc == 7'h63);
      is_lui = (opc == 7'h37);
      is_jal = (opc == 7'h6F);
      legal  = is_op | is_opi | is_ld | is_st | is_br | is_lui | is_jal;

      for (int unsigned k = 0; k <= fw; k++)
         step(i, k == fw, 1'($urandom), ev(1,0,k == fw,0,0,0,0,0,0,0,0,3'd0,0), "fetch", 0);
      step(i, 1'($urandom), 1'($urandom), ev(0,0,0,1,0,0,0,0,0,0,0,3'd1,0), "decode", 0);

      sa = 2'd0; sb = 2'd0; op = 4'd0; ps = 2'd0; pcw = 0;
      taken = ((f3 == 3'd0) && az) || ((f3 == 3'd1) && !az);
      if (is_op)  op = {(f3 == 3'd0 || f3 == 3'd5) ? i[30] : 1'b0, f3};
      if (is_opi) begin sb = 2'd1; op = {i[30] && (f3 == 3'd5), f3}; end
      if (is_ld || is_st) sb = 2'd1;
      if (is_lui) begin sa = 2'd2; sb = 2'd1; end
      if (is_br) begin op = 4'b1000; pcw = 1; ps = taken ? 2'd1 : 2'd0; end
`ifndef ILLEGAL_TRAP_EN
      if (!legal) pcw = 1;
`endif
      step(i, 1'($urandom), az, ev(0,0,0,0,pcw,ps,sa,sb,op,0,0,3'd2,0), "exec", pcw);

      if (is_ld || is_st)
         for (int unsigned k = 0; k <= mw; k++)
            step(i, k == mw, 1'($urandom),
                 ev(is_ld,is_st,0,0,is_st && k == mw,0,0,0,0,0,0,3'd3,0), "mem", is_st && k == mw);

      if (is_op || is_opi || is_lui || is_jal || is_ld)
         step(i, 1'($urandom), 1'($urandom),
              ev(0,0,0,0,1,is_jal ? 2'd2 : 2'd0,0,0,0,is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0),1,3'd4,0),
              "wb", 1);

`ifdef ILLEGAL_TRAP_EN
      if (!legal) begin
         for (int unsigned k = 0; k < 3; k++)
            step(i, 1'($urandom), 1'($urandom), ev(0,0,0,0,0,0,0,0,0,0,0,3'd5,1), "trap", 0);
         do_reset();
      end
`endif
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      int unsigned k;
      r = $urandom;
      k = $urandom_range(0, 14);
      case (k)
         0, 1:   r[6:0] = 7'h33;
         2, 3:   r[6:0] = 7'h13;
         4, 5:   r[6:0] = 7'h03;
         6, 7:   r[6:0] = 7'h23;
         8, 9:   begin r[6:0] = 7'h63; r[14:12] = {2'b00, r[20]}; end
         10, 11: r[6:0] = 7'h37;
         12, 13: r[6:0] = 7'h6F;
         default: r[6:0] = (r[25]) ? 7'h7F : 7'h0F;
      endcase
      return r;
   endfunction

   initial begin
      do_reset();

      // Directed cases
      run_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
      run_instr(32'h40208033, 0, 0, 1'b0);   // sub
      run_instr(32'h4020D033, 1, 0, 1'b0);   // sra
      run_instr(32'h4020D093, 0, 0, 1'b0);   // srai
      run_instr(32'h00208463, 0, 0, 1'b1);   // beq taken
      run_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
      run_instr(32'h00209463, 0, 0, 1'b0);   // bne taken
      run_instr(32'h0000A083, 0, 3, 1'b0);   // lw, 3 wait cycles
      run_instr(32'h0020A023, 0, 2, 1'b0);   // sw, 2 wait cycles
      run_instr(32'h123450B7, 0, 0, 1'b0);   // lui
      run_instr(32'h008000EF, 2, 0, 1'b0);   // jal

      // Reset asserted mid-store while mem_we is held
      step(32'h0020A023, 1'b1, 1'b0, ev(1,0,1,0,0,0,0,0,0,0,0,3'd0,0), "st_fetch", 0);
      step(32'h0020A023, 1'b0, 1'b0, ev(0,0,0,1,0,0,0,0,0,0,0,3'd1,0), "st_decode", 0);
      step(32'h0020A023, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,2'd1,0,0,0,3'd2,0), "st_exec", 0);
      step(32'h0020A023, 1'b0, 1'b0, ev(0,1,0,0,0,0,0,0,0,0,0,3'd3,0), "st_mem_wait", 0);
      @(negedge clk);
      mem_ready = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rst_mid_store_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mid_store_state", 32'(state), 32'd0);
      chk("rst_mid_store_instret", 32'(instret), 32'd0);
      exp_instret = '0;
      @(negedge clk);
      rst = 1'b0;

      // Illegal opcode
      run_instr(32'h0000007F, 0, 0, 1'b0);

      // Random stream; enough retirements to wrap the narrow counter
      for (int n = 0; n < 120; n++)
         run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));

      do_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
